// File: rtl/task_frame_arb_pkg.sv
// Shared types and default parameters for the task frame arbiter.
// Imported by the interface-facing top and the round-robin picker.
package task_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER,
        ST_WAIT_OUT
    } state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/task_frame_arb_if.sv
// Frame-source / task-input bundle between the sources and the arbiter.
// The master side drives the i_* signals, the slave side (arbiter) drives the o_* signals.
interface task_frame_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ-1:0]            i_tdata_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_tdata;
    logic [NUM_REQ-1:0]            i_tdata_last;
    logic                          i_tready;
    logic                          i_output_last;
    logic [NUM_REQ-1:0]            o_tready;
    logic [DATA_WIDTH-1:0]         o_tdata;
    logic                          o_tdata_valid;
    logic                          o_tdata_last;
    logic [NUM_REQ-1:0]            o_grant;
    logic                          o_busy;
    logic                          o_timeout;

    modport master (
        output i_req, i_tdata_valid, i_tdata, i_tdata_last,
        output i_tready, i_output_last,
        input  o_tready, o_tdata, o_tdata_valid, o_tdata_last,
        input  o_grant, o_busy, o_timeout
    );

    modport slave (
        input  i_req, i_tdata_valid, i_tdata, i_tdata_last,
        input  i_tready, i_output_last,
        output o_tready, o_tdata, o_tdata_valid, o_tdata_last,
        output o_grant, o_busy, o_timeout
    );
endinterface

// File: rtl/task_frame_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping; returns a one-hot grant (zero when nothing requests).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);
    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_sel;
    logic               w_found;

    // Rotate so the pointer position is bit 0, pick lowest, rotate back.
    always_comb begin
        w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rot[i] && !w_found) begin
                w_sel[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        o_grant = NUM_REQ'(({w_sel, w_sel} << i_ptr) >> NUM_REQ);
    end
endmodule

// File: rtl/task_frame_arb.sv
// Arbitrates whole frames from NUM_REQ sources onto one task input path,
// holding the owner until the task engine reports its final output word.
module task_frame_arb
    import task_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic              i_clk,
    input logic              i_rst,
    task_frame_arb_if.slave  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                r_state;
    state_t                w_next;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    w_arb_grant;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         w_gidx;
    logic [PW-1:0]         w_ptr_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_timeout;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_src_valid;
    logic                  w_src_last;
    logic                  w_xfer;
    logic                  w_fwd_valid;
    logic                  w_done;
    logic                  w_expire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .i_req   (bus.i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        w_gidx      = '0;
        w_data      = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx      = PW'(i);
                w_data      = bus.i_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_src_valid = bus.i_tdata_valid[i];
                w_src_last  = bus.i_tdata_last[i];
            end
        end
    end

    assign w_xfer      = (r_state == ST_XFER);
    assign w_fwd_valid = w_xfer & w_src_valid & bus.i_tready;
    assign w_done      = (r_state == ST_WAIT_OUT) & bus.i_output_last;
    // Output completion beats the timeout when both land together.
    assign w_expire    = (r_state == ST_WAIT_OUT) & ~bus.i_output_last
                       & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_ptr_next  = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + PW'(1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:     if (|bus.i_req) w_next = ST_ARB;
            ST_ARB:      w_next = (|bus.i_req) ? ST_XFER : ST_IDLE;
            ST_XFER:     if (w_fwd_valid && w_src_last) w_next = ST_WAIT_OUT;
            ST_WAIT_OUT: if (w_done || w_expire) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant   <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            r_cnt     <= (r_state == ST_WAIT_OUT) ? r_cnt + CW'(1) : '0;
            if (r_state == ST_ARB) r_grant <= w_arb_grant;
            if (w_done || w_expire) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_next;
            end
        end
    end

    assign bus.o_tready      = w_xfer ? (r_grant & {NUM_REQ{bus.i_tready}}) : '0;
    assign bus.o_tdata       = w_xfer ? w_data : '0;
    assign bus.o_tdata_valid = w_fwd_valid;
    assign bus.o_tdata_last  = w_fwd_valid & w_src_last;
    assign bus.o_grant       = r_grant;
    assign bus.o_busy        = (r_state != ST_IDLE);
    assign bus.o_timeout     = r_timeout;
endmodule

// File: tb/tb_task_frame_arb.sv
// Self-checking bench for task_frame_arb: directed tables, corner sequences
// and randomized frames against a frame-level round-robin model.
module tb_task_frame_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    task_frame_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    task_frame_arb #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
    } vec_t;

    int           n_cmp = 0;
    int           n_err = 0;
    int           m_ptr = 0;
    logic [DW-1:0] fwd_q[$];
    logic [DW-1:0] exp_q[$];
    vec_t         tbl[8];
    logic [N-1:0] gs;

    always @(negedge clk) if (bus.o_tdata_valid) fwd_q.push_back(bus.o_tdata);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_req         = '0;
        bus.i_tdata_valid = '0;
        bus.i_tdata       = '0;
        bus.i_tdata_last  = '0;
        bus.i_tready      = 1'b0;
        bus.i_output_last = 1'b0;
    endtask

    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", bus.o_grant, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_tready", bus.o_tready, 0);
        chk("rst_valid", bus.o_tdata_valid, 0);
        chk("rst_last", bus.o_tdata_last, 0);
        chk("rst_timeout", bus.o_timeout, 0);
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    // mode: 0 tready always 1, 1 toggling, 2 random; dly >= T forces a timeout
    task automatic do_frame(input logic [N-1:0] req, input int nb, input int mode,
                            input int dly, input bit drop,
                            output logic [N-1:0] gseen);
        int   g;
        int   sent;
        int   cyc;
        int   tos;
        logic tr;
        logic [DW-1:0] d;
        g = model_pick(req, m_ptr);
        fwd_q.delete();
        exp_q.delete();
        bus.i_req = req;
        for (cyc = 0; cyc < 6 && bus.o_grant == 0; cyc++) tick();
        gseen = bus.o_grant;
        chk("grant", bus.o_grant, 32'(1) << g);
        chk("busy_xfer", bus.o_busy, 1);
        sent = 0;
        cyc  = 0;
        while (sent < nb && cyc < 8 * nb + 8) begin
            if (mode == 0)              tr = 1'b1;
            else if (mode == 1)         tr = (cyc % 2 == 0);
            else if (cyc >= 4 * nb)     tr = 1'b1;
            else                        tr = 1'($urandom_range(0, 1));
            d = DW'($urandom);
            for (int s = 0; s < N; s++) begin
                bus.i_tdata_valid[s]   = (s == g) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.i_tdata[s*DW +: DW] = (s == g) ? d : DW'($urandom);
                bus.i_tdata_last[s]    = (s == g) ? (sent == nb - 1)
                                                  : 1'($urandom_range(0, 1));
            end
            bus.i_tready      = tr;
            bus.i_output_last = 1'($urandom_range(0, 1));
            if (drop && sent > 0) bus.i_req[g] = 1'b0;
            #1;
            chk("tready", bus.o_tready, tr ? (32'(1) << g) : 0);
            chk("fwd_valid", bus.o_tdata_valid, tr);
            chk("fwd_last", bus.o_tdata_last, tr && (sent == nb - 1));
            if (tr) begin
                chk("fwd_data", bus.o_tdata, d);
                exp_q.push_back(d);
                sent++;
            end
            tick();
            cyc++;
        end
        chk("xfer_bound", sent, nb);
        bus.i_tdata_valid = '0;
        bus.i_tdata_last  = '0;
        bus.i_output_last = 1'b0;
        bus.i_tready      = 1'($urandom_range(0, 1));
        tos = 0;
        for (int k = 0; k <= T; k++) begin
            bus.i_output_last = (k == dly);
            #1;
            chk("wait_tready", bus.o_tready, 0);
            chk("wait_grant", bus.o_grant, 32'(1) << g);
            tick();
            if (bus.o_timeout) tos++;
            if (k == dly || k == T - 1) break;
        end
        bus.i_output_last = 1'b0;
        chk("end_busy", bus.o_busy, 0);
        chk("end_grant", bus.o_grant, 0);
        tick();
        if (bus.o_timeout) tos++;
        chk("timeout_pulses", tos, (dly > T - 1) ? 1 : 0);
        chk("fwd_count", fwd_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < fwd_q.size(); i++)
            chk("fwd_order", fwd_q[i], exp_q[i]);
        m_ptr = (g + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0001, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b0011, 4'b0001};
        tbl[3] = '{4'b1000, 4'b1000};
        tbl[4] = '{4'b0110, 4'b0010};
        tbl[5] = '{4'b0101, 4'b0100};
        tbl[6] = '{4'b0101, 4'b0001};
        tbl[7] = '{4'b1100, 4'b0100};
        idle_inputs();
        do_reset();

        do_frame(4'b0001, 3, 0, 10, 1'b0, gs);
        chk("single_src_grant", gs, 4'b0001);
        do_frame(4'b0011, 1, 0, 2, 1'b0, gs);
        chk("ptr_after_src0", gs, 4'b0010);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_frame(4'b1111, 1 + i % 3, 0, 1, 1'b0, gs);
            chk("rr_order", gs, 32'(1) << (i % N));
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_frame(tbl[i].req, 2, i % 3, i, (i == 5), gs);
            chk("tbl_grant", gs, tbl[i].gnt);
        end

        do_frame(4'b1111, 1, 0, T - 1, 1'b0, gs);
        chk("tie_grant", gs, 4'b1000);
        do_frame(4'b1111, 2, 1, T + 5, 1'b0, gs);
        chk("to_grant", gs, 4'b0001);
        do_frame(4'b1111, 1, 0, 0, 1'b0, gs);
        chk("after_to_grant", gs, 4'b0010);
        do_frame(4'b0100, 5, 1, 4, 1'b0, gs);

        do_reset();
        bus.i_req = 4'b0100;
        for (int c = 0; c < 6 && bus.o_grant == 0; c++) tick();
        chk("pre_rst_grant", bus.o_grant, 4'b0100);
        bus.i_tdata_valid[2] = 1'b1;
        bus.i_tdata[2*DW +: DW] = 8'h5a;
        bus.i_tready = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tready", bus.o_tready, 0);
        chk("midrst_grant", bus.o_grant, 0);
        chk("midrst_busy", bus.o_busy, 0);
        chk("midrst_valid", bus.o_tdata_valid, 0);
        idle_inputs();
        tick();
        rst   = 1'b0;
        m_ptr = 0;
        do_frame(4'b0101, 2, 0, 3, 1'b0, gs);
        chk("post_rst_grant", gs, 4'b0001);

        for (int i = 0; i < 40; i++) begin
            do_frame(N'($urandom_range(1, 15)), $urandom_range(1, 4),
                     $urandom_range(0, 2), $urandom_range(0, T + 3),
                     1'($urandom_range(0, 1)), gs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/task_frame_arb.md
TASK_FRAME_ARB -- requirements
Module: task_frame_arb

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of frame sources sharing the task input path.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, stream data width per source.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 4096, maximum cycles spent waiting for task output completion.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: i_clk  in  1  sole clock, rising edge; i_rst  in  1  async active-high reset.
REQ-005 SHALL have: i_req  in  NUM_REQ  per-source frame-pending flag.
REQ-006 SHALL have: i_tdata_valid  in  NUM_REQ  per-source beat valid.
REQ-007 SHALL have: i_tdata  in  NUM_REQ*DATA_WIDTH  per-source data, source k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have: i_tdata_last  in  NUM_REQ  per-source last beat of frame.
REQ-009 SHALL have: i_tready  in  1  task input block ready to accept a beat.
REQ-010 SHALL have: i_output_last  in  1  task engine emitted its final output word.
REQ-011 SHALL have: o_tready  out  NUM_REQ  per-source ready; at most one bit set.
REQ-012 SHALL have: o_tdata, o_tdata_valid, o_tdata_last  out  DATA_WIDTH/1/1  muxed stream to the task input block.
REQ-013 SHALL have: o_grant  out  NUM_REQ  one-hot current owner; o_busy  out  1  not IDLE; o_timeout  out  1  single-cycle timeout pulse.

Function
REQ-014 SHALL implement states IDLE, ARB, XFER, WAIT_OUT.
REQ-015 IDLE: when any i_req bit is 1, SHALL go to ARB next cycle; otherwise stay.
REQ-016 ARB: SHALL register o_grant to the first set i_req bit searching upward (wrapping) from rr_ptr, then go to XFER; if i_req became all-zero, SHALL return to IDLE with o_grant = 0.
REQ-017 XFER: o_tready[g] SHALL equal i_tready combinationally for granted source g; all other o_tready bits 0.
REQ-018 XFER: o_tdata/o_tdata_valid/o_tdata_last SHALL be combinational copies of source g, valid gated by i_tready; zero-latency passthrough.
REQ-019 A beat transfers when i_tdata_valid[g] & o_tready[g]; transfer with i_tdata_last[g] SHALL move to WAIT_OUT next cycle, so o_tready is 0 from that cycle.
REQ-020 WAIT_OUT: SHALL hold o_grant, keep all o_tready 0, and count cycles from 0; on i_output_last SHALL go to IDLE, clear o_grant, set rr_ptr = (g+1) mod NUM_REQ.
REQ-021 WAIT_OUT: if counter reaches TIMEOUT_CYCLES-1 without i_output_last, SHALL pulse o_timeout for one cycle, go to IDLE, and advance rr_ptr as in REQ-020.
REQ-022 i_output_last and timeout in the same cycle: i_output_last SHALL win; no o_timeout pulse.
REQ-023 i_output_last outside WAIT_OUT SHALL be ignored.
REQ-024 Deassertion of i_req[g] during XFER SHALL NOT abort the frame; only the last beat ends XFER.
REQ-025 Valid beats from non-granted sources SHALL be ignored and never forwarded.
REQ-026 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 and SHALL clear on every WAIT_OUT entry.
REQ-027 o_busy SHALL be 1 in ARB, XFER, WAIT_OUT.

Reset
REQ-028 On i_rst (async assert): state = IDLE, rr_ptr = 0, o_grant = 0, counter = 0, o_timeout = 0; o_tready, o_tdata_valid, o_tdata_last, o_busy = 0.
REQ-029 Reset mid-frame SHALL drop the frame; first grant after release SHALL favour source 0.

Structure
REQ-030 Package task_arb_pkg SHALL hold the state enum and default parameter constants.
REQ-031 Priority selection SHALL be a sub-module rr_arbiter (request vector + pointer in, one-hot grant out, combinational).

Verification
REQ-032 i_req=0b0001, 3-beat frame, i_tready=1, i_output_last 10 cycles later -> 3 beats forwarded, o_tdata_last on beat 3, IDLE after i_output_last, rr_ptr=1.
REQ-033 i_req=0b1111 held, 4 frames -> grant order 0,1,2,3, then 0 again.
REQ-034 i_tready toggling 1/0 during XFER -> forwarded beats only when i_tready=1, none lost or duplicated.
REQ-035 No i_output_last for TIMEOUT_CYCLES -> o_timeout pulse exactly once, IDLE, next source granted.
REQ-036 i_rst asserted mid-XFER of source 2 -> o_tready and o_grant 0 immediately; after release, i_req=0b0101 grants source 0.
